// File: rtl/gvp_nch_if.sv
// Bus between the PS vector-programming registers and the gvp_nch sequencer.
// master drives program/control, slave (the sequencer) returns positions and status.
interface gvp_nch_if #(
    parameter int NCH = 6,
    parameter int W   = 32
);
    logic                     hold;
    logic                     pause;
    logic                     setvec;
    logic [(6+NCH)*W-1:0]     vp_set;
    logic [NCH*W-1:0]         pos;
    logic [W-1:0]             options;
    logic [W-1:0]             section;
    logic [1:0]               store_data;
    logic                     gvp_finished;
    logic                     gvp_error;

    modport master (
        output hold, pause, setvec, vp_set,
        input  pos, options, section, store_data, gvp_finished, gvp_error
    );

    modport slave (
        input  hold, pause, setvec, vp_set,
        output pos, options, section, store_data, gvp_finished, gvp_error
    );
endinterface

// File: rtl/gvp_nch.sv
// General vector program sequencer: walks a table of sections, accumulating NCH position channels.
// Define GVP_SAT_EN to make each channel add saturate instead of wrapping.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | hold/program mode, table writable, pos retained
// LOAD  | fetch entry pc, END check, latch section counters
// WAIT  | inter-step delay, wait_cnt holds remaining WAIT cycles
// STEP  | add increments to all channels, pick next step or next pc
// FIN   | program ended (normally or by range error) until hold
module gvp_nch #(
    parameter int NCH   = 6,
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic     a_clk,
    input  logic     a_resetn,
    gvp_nch_if.slave gvp
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = (5 + NCH) * W;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, STEP, FIN} state_t;

    state_t             state, state_nxt;
    logic [EW-1:0]      vtab [DEPTH];
    logic [EW-1:0]      ent;
    logic [AW-1:0]      pc, pc_nxt;
    logic [W-1:0]       step_cnt, step_nxt;
    logic [W-1:0]       wait_cnt, wait_nxt;
    logic [W-1:0]       rep, rep_nxt;
    logic               armed, armed_nxt;
    logic [NCH*W-1:0]   pos_r, pos_nxt;
    logic [W-1:0]       options_r, options_nxt;
    logic [W-1:0]       section_r, section_nxt;
    logic [1:0]         sd_r, sd_nxt;
    logic               fin_r, fin_nxt;
    logic               err_r, err_nxt;
    logic [W-1:0]       e_n, e_nii, e_opt, e_nrep, e_next;
    logic               take_jump;
    logic [W:0]         tgt;

    function automatic logic [W-1:0] ch_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef GVP_SAT_EN
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    // Table has no reset so a program survives a_resetn; Vadr is not stored.
    always_ff @(posedge a_clk) begin
        if (gvp.hold && gvp.setvec && (gvp.vp_set[W-1:0] < W'(DEPTH)))
            vtab[gvp.vp_set[AW-1:0]] <= gvp.vp_set[W +: EW];
    end

    assign ent    = vtab[pc];
    assign e_n    = ent[0   +: W];
    assign e_nii  = ent[W   +: W];
    assign e_opt  = ent[2*W +: W];
    assign e_nrep = ent[3*W +: W];
    assign e_next = ent[4*W +: W];

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        step_nxt    = step_cnt;
        wait_nxt    = wait_cnt;
        rep_nxt     = rep;
        armed_nxt   = armed;
        pos_nxt     = pos_r;
        options_nxt = options_r;
        section_nxt = section_r;
        sd_nxt      = 2'd0;
        fin_nxt     = fin_r;
        err_nxt     = err_r;
        take_jump   = 1'b0;
        tgt         = '0;

        if (gvp.hold) begin
            state_nxt   = IDLE;
            options_nxt = '0;
            fin_nxt     = 1'b0;
            err_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc_nxt      = '0;
                    section_nxt = '0;
                    armed_nxt   = 1'b0;
                    state_nxt   = LOAD;
                end
                LOAD: if (!gvp.pause) begin
                    if (e_n == '0) begin
                        fin_nxt   = 1'b1;
                        state_nxt = FIN;
                    end else begin
                        options_nxt = e_opt;
                        section_nxt = section_r + W'(1);
                        sd_nxt      = 2'd2;
                        step_nxt    = e_n;
                        wait_nxt    = e_nii;
                        state_nxt   = (e_nii == '0) ? STEP : WAIT;
                    end
                end
                WAIT: if (!gvp.pause) begin
                    wait_nxt = wait_cnt - W'(1);
                    if (wait_cnt <= W'(1))
                        state_nxt = STEP;
                end
                STEP: if (!gvp.pause) begin
                    for (int k = 0; k < NCH; k++)
                        pos_nxt[k*W +: W] = ch_add(pos_r[k*W +: W], ent[(5+k)*W +: W]);
                    sd_nxt   = 2'd1;
                    step_nxt = step_cnt - W'(1);
                    if (step_cnt > W'(1)) begin
                        wait_nxt  = e_nii;
                        state_nxt = (e_nii == '0) ? STEP : WAIT;
                    end else begin
                        // Single loop level: body runs Nrep+1 times, then falls through.
                        if (e_nrep != '0) begin
                            if (!armed) begin
                                armed_nxt = 1'b1;
                                rep_nxt   = e_nrep - W'(1);
                                take_jump = 1'b1;
                            end else if (rep != '0) begin
                                rep_nxt   = rep - W'(1);
                                take_jump = 1'b1;
                            end else begin
                                armed_nxt = 1'b0;
                            end
                        end
                        tgt = take_jump ? ({1'b0, W'(pc)} + {e_next[W-1], e_next})
                                        : ({1'b0, W'(pc)} + (W+1)'(1));
                        if (tgt[W] || (tgt >= (W+1)'(DEPTH))) begin
                            err_nxt   = 1'b1;
                            fin_nxt   = 1'b1;
                            state_nxt = FIN;
                        end else begin
                            pc_nxt    = tgt[AW-1:0];
                            state_nxt = LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state     <= IDLE;
            pc        <= '0;
            step_cnt  <= '0;
            wait_cnt  <= '0;
            rep       <= '0;
            armed     <= 1'b0;
            pos_r     <= '0;
            options_r <= '0;
            section_r <= '0;
            sd_r      <= 2'd0;
            fin_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            step_cnt  <= step_nxt;
            wait_cnt  <= wait_nxt;
            rep       <= rep_nxt;
            armed     <= armed_nxt;
            pos_r     <= pos_nxt;
            options_r <= options_nxt;
            section_r <= section_nxt;
            sd_r      <= sd_nxt;
            fin_r     <= fin_nxt;
            err_r     <= err_nxt;
        end
    end

    assign gvp.pos          = pos_r;
    assign gvp.options      = options_r;
    assign gvp.section      = section_r;
    assign gvp.store_data   = sd_r;
    assign gvp.gvp_finished = fin_r;
    assign gvp.gvp_error    = err_r;
endmodule

// File: tb/tb_gvp_nch.sv
// Scoreboard bench for gvp_nch: a program interpreter predicts every store_data pulse,
// final position, section count, error flag and run length.
module tb_gvp_nch;
    localparam int NCH   = 6;
    localparam int W     = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [NCH-1:0][W-1:0] d;
        logic [W-1:0]          next;
        logic [W-1:0]          nrep;
        logic [W-1:0]          opt;
        logic [W-1:0]          nii;
        logic [W-1:0]          n;
    } vec_t;

    typedef struct packed {
        logic [1:0]       kind;
        logic [NCH*W-1:0] pos;
        logic [W-1:0]     opt;
        logic [W-1:0]     sec;
    } ev_t;

    logic a_clk    = 1'b0;
    logic a_resetn = 1'b0;

    gvp_nch_if #(.NCH(NCH), .W(W)) gvp ();

    gvp_nch #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) u_dut (
        .a_clk    (a_clk),
        .a_resetn (a_resetn),
        .gvp      (gvp)
    );

    always #5 a_clk = ~a_clk;

    int                    n_cmp = 0;
    int                    n_bad = 0;
    vec_t                  mtab [DEPTH];
    logic [NCH-1:0][W-1:0] mpos;
    ev_t                   exp_q [$];
    ev_t                   mon_e;
    int                    exp_sec;
    bit                    exp_err;

    task automatic chk(input string name, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        longint hi;
        longint lo;
        s  = longint'($signed(a)) + longint'($signed(b));
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
`ifdef GVP_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`endif
        return W'(s);
    endfunction

    function automatic vec_t mk(input int n, input int nii, input int nrep, input int next);
        vec_t v;
        v      = '0;
        v.n    = W'(n);
        v.nii  = W'(nii);
        v.nrep = W'(nrep);
        v.next = W'(next);
        v.opt  = W'($urandom);
        return v;
    endfunction

    // Interpreter over the model table; pushes one event per expected pulse.
    task automatic model_run(output int cyc);
        int   pc;
        int   tgt;
        int   rep;
        int   sec;
        bit   armed;
        bit   jump;
        vec_t v;
        pc = 0; rep = 0; sec = 0; armed = 0; cyc = 0; exp_err = 0;
        for (int guard = 0; guard < 2000; guard++) begin
            v = mtab[pc];
            cyc++;
            if (v.n == '0) break;
            sec++;
            exp_q.push_back('{kind: 2'd2, pos: mpos, opt: v.opt, sec: W'(sec)});
            for (int s = 0; s < int'(v.n); s++) begin
                cyc += int'(v.nii) + 1;
                for (int k = 0; k < NCH; k++) mpos[k] = madd(mpos[k], v.d[k]);
                exp_q.push_back('{kind: 2'd1, pos: mpos, opt: v.opt, sec: W'(sec)});
            end
            jump = 0;
            if (v.nrep != '0) begin
                if (!armed) begin armed = 1; rep = int'(v.nrep) - 1; jump = 1; end
                else if (rep > 0) begin rep--; jump = 1; end
                else armed = 0;
            end
            tgt = jump ? pc + int'($signed(v.next)) : pc + 1;
            if (tgt < 0 || tgt >= DEPTH) begin exp_err = 1; break; end
            pc = tgt;
        end
        exp_sec = sec;
    endtask

    task automatic write_vec(input int addr, input vec_t v);
        @(negedge a_clk);
        gvp.vp_set = {v, W'(addr)};
        gvp.setvec = 1'b1;
        @(negedge a_clk);
        gvp.setvec = 1'b0;
        if (gvp.hold && addr >= 0 && addr < DEPTH) mtab[addr] = v;
    endtask

    task automatic run_prog(input int pause_at, input int pause_len, input bit bad_write, output int elapsed);
        int                cyc;
        int                n;
        bit                done;
        logic [NCH*W-1:0]  held;
        vec_t              bv;
        model_run(cyc);
        if (pause_at + pause_len > cyc) pause_len = 0;
        bv = mk(3, 0, 0, 0);
        for (int k = 0; k < NCH; k++) bv.d[k] = W'(7);
        held = '0;
        @(negedge a_clk);
        gvp.hold = 1'b0;
        n = 0;
        done = 0;
        while (!done && n < 20000) begin
            @(posedge a_clk);
            n++;
            @(negedge a_clk);
            if (pause_len > 0 && n > pause_at && n <= pause_at + pause_len) begin
                chk("pause_store_data", gvp.store_data, 0);
                chk("pause_pos", gvp.pos, held);
            end
            if (pause_len > 0 && n == pause_at) begin
                held      = gvp.pos;
                gvp.pause = 1'b1;
            end
            if (n == pause_at + pause_len) gvp.pause = 1'b0;
            if (bad_write && n == 2) begin
                gvp.vp_set = {bv, W'(0)};
                gvp.setvec = 1'b1;
            end
            if (bad_write && n == 3) gvp.setvec = 1'b0;
            done = gvp.gvp_finished;
        end
        gvp.pause  = 1'b0;
        gvp.setvec = 1'b0;
        #2;
        chk("finish_seen", done, 1);
        chk("run_cycles", n, cyc + 1 + pause_len);
        chk("final_pos", gvp.pos, mpos);
        chk("final_section", gvp.section, exp_sec);
        chk("final_error", gvp.gvp_error, exp_err);
        chk("pulses_outstanding", exp_q.size(), 0);
        exp_q.delete();
        elapsed = n;
    endtask

    task automatic release_hold();
        @(negedge a_clk);
        gvp.hold = 1'b1;
        @(negedge a_clk);
        chk("hold_clr_finished", gvp.gvp_finished, 0);
        chk("hold_clr_error", gvp.gvp_error, 0);
        chk("hold_clr_options", gvp.options, 0);
    endtask

    always @(negedge a_clk) begin
        if (a_resetn && gvp.store_data != 2'd0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_pulse: got store_data=%0d expected no pulse", gvp.store_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", gvp.store_data, mon_e.kind);
                chk("pulse_pos", gvp.pos, mon_e.pos);
                chk("pulse_options", gvp.options, mon_e.opt);
                chk("pulse_section", gvp.section, mon_e.sec);
            end
        end
    end

    initial begin
        vec_t v;
        int   el;
        int   len;
        gvp.hold   = 1'b1;
        gvp.pause  = 1'b0;
        gvp.setvec = 1'b0;
        gvp.vp_set = '0;
        mpos       = '0;
        for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
        repeat (3) @(negedge a_clk);
        chk("rst_pos", gvp.pos, 0);
        chk("rst_options", gvp.options, 0);
        chk("rst_section", gvp.section, 0);
        chk("rst_store_data", gvp.store_data, 0);
        chk("rst_finished", gvp.gvp_finished, 0);
        chk("rst_error", gvp.gvp_error, 0);
        a_resetn = 1'b1;

        // move program
        v = mk(5, 2, 0, 0); v.d[0] = -2; v.d[1] = -2; v.d[3] = 1;  write_vec(0, v);
        v = mk(5, 2, 0, 0); v.d[0] = 2;  v.d[1] = 2;  v.d[3] = -1; write_vec(1, v);
        write_vec(2, mk(0, 0, 0, 0));
        run_prog(0, 0, 0, el);
        chk("move_cycles", el, 34);
        chk("move_pos_zero", gvp.pos, 0);
        chk("move_section", gvp.section, 2);
        release_hold();

        // scan program continuing from current position
        v = mk(10, 2, 0, 0);  v.d[0] = 2;  write_vec(0, v);
        v = mk(10, 2, 0, 0);  v.d[0] = -2; write_vec(1, v);
        v = mk(1, 2, 10, -2); v.d[1] = 2;  write_vec(2, v);
        write_vec(3, mk(0, 0, 0, 0));
        run_prog(0, 0, 0, el);
        chk("scan_x", gvp.pos[0 +: W], 0);
        chk("scan_y", gvp.pos[W +: W], 22);
        chk("scan_section", gvp.section, 33);
        chk("scan_error", gvp.gvp_error, 0);
        release_hold();

        // out-of-range jump, with an ignored write during the run
        v = mk(1, 0, 1, -1); v.d[0] = 5; write_vec(0, v);
        run_prog(0, 0, 1, el);
        chk("jump_error", gvp.gvp_error, 1);
        chk("jump_finished", gvp.gvp_finished, 1);
        release_hold();
        run_prog(0, 0, 0, el);
        chk("jump_rerun_error", gvp.gvp_error, 1);
        release_hold();

        // pause for 7 cycles mid-WAIT
        v = mk(2, 5, 0, 0); v.d[0] = 1; write_vec(0, v);
        write_vec(1, mk(0, 0, 0, 0));
        run_prog(3, 7, 0, el);
        chk("pause_extend", el, 22);
        release_hold();

        // reset mid-STEP; out-of-range write must not alias onto entry 0
        v = mk(20, 0, 0, 0); v.d[0] = 3; v.d[2] = -1; write_vec(0, v);
        write_vec(1, mk(0, 0, 0, 0));
        v = mk(1, 0, 0, 0); v.d[0] = 1000; write_vec(DEPTH, v);
        model_run(el);
        @(negedge a_clk);
        gvp.hold = 1'b0;
        repeat (5) @(posedge a_clk);
        #2;
        a_resetn = 1'b0;
        #1;
        chk("arst_pos", gvp.pos, 0);
        chk("arst_options", gvp.options, 0);
        chk("arst_section", gvp.section, 0);
        chk("arst_store_data", gvp.store_data, 0);
        chk("arst_finished", gvp.gvp_finished, 0);
        chk("arst_error", gvp.gvp_error, 0);
        exp_q.delete();
        mpos     = '0;
        gvp.hold = 1'b1;
        @(negedge a_clk);
        a_resetn = 1'b1;
        run_prog(0, 0, 0, el);
        chk("table_kept_x", gvp.pos[0 +: W], 60);
        release_hold();

        // saturation vs wrap near the positive limit
        v = mk(1, 0, 0, 0); v.d[0] = 32'h7FFF_FFFE - 60; write_vec(0, v);
        v = mk(1, 0, 0, 0); v.d[0] = 4;                  write_vec(1, v);
        write_vec(2, mk(0, 0, 0, 0));
        run_prog(0, 0, 0, el);
`ifdef GVP_SAT_EN
        chk("sat_x", gvp.pos[0 +: W], 32'h7FFF_FFFF);
`else
        chk("wrap_x", gvp.pos[0 +: W], 32'h8000_0002);
`endif
        release_hold();

        // randomized programs with forward jumps, loops and occasional bad targets
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 6);
            for (int a = 0; a < DEPTH; a++) begin
                if (a < len) begin
                    v = mk($urandom_range(1, 4), $urandom_range(0, 3),
                           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0,
                           ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3));
                    for (int k = 0; k < NCH; k++) v.d[k] = W'($urandom);
                end else begin
                    v = mk(0, 0, 0, 0);
                end
                write_vec(a, v);
            end
            run_prog($urandom_range(1, 4), $urandom_range(0, 4), 0, el);
            release_hold();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
